// File: rtl/rst_seq_pkg.sv
// rst_seq shared types: sequencer states, reset cause codes
// and a small helper for sizing the shared cycle counter.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ASSERT,
    WAIT_LOCK,
    STAB,
    REL_PERIPH,
    RUN
  } state_e;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_BTN = 2'b01;
  localparam logic [1:0] CAUSE_PLL = 2'b10;
  localparam logic [1:0] CAUSE_SW  = 2'b11;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Board-side conditioning inputs and SoC reset outputs
// of the reset sequencer, bundled for the top-level port.
interface rst_seq_if;
  logic       pll_locked_i;
  logic       btn_rst_n_i;
  logic       sw_rst_req_i;
  logic       periph_rst_o;
  logic       cpu_rst_o;
  logic [1:0] rst_cause_o;
  logic       run_o;

  modport master (
    output pll_locked_i,
    output btn_rst_n_i,
    output sw_rst_req_i,
    input  periph_rst_o,
    input  cpu_rst_o,
    input  rst_cause_o,
    input  run_o
  );

  modport slave (
    input  pll_locked_i,
    input  btn_rst_n_i,
    input  sw_rst_req_i,
    output periph_rst_o,
    output cpu_rst_o,
    output rst_cause_o,
    output run_o
  );
endinterface

// File: rtl/rst_seq_sync_debounce.sv
// Multi-flop synchronizer with an optional level debouncer.
// DEBOUNCE_CYC <= 1 passes the synchronized level straight through.
module rst_seq_sync_debounce #(
  parameter int   SYNC_STAGES  = 2,
  parameter int   DEBOUNCE_CYC = 1,
  parameter logic RST_VAL      = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic level_o
);

  localparam int CW = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [CW-1:0] DB_T = CW'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] chain;
  logic                   synced;
  logic [CW-1:0]          cnt;
  logic                   state;

  assign synced = chain[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_i};
    end
  end

  // Accept a new level only after DEBOUNCE_CYC back-to-back
  // disagreeing samples; any agreeing sample restarts the run.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= RST_VAL;
      cnt   <= '0;
    end else if (synced == state) begin
      cnt <= '0;
    end else if (cnt == DB_T) begin
      state <= synced;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign level_o = (DEBOUNCE_CYC <= 1) ? synced : state;

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: holds the SoC in reset until PLL lock is stable,
// releases peripherals then CPU, and records why it last re-entered reset.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYC      = 80000,
  parameter int LOCK_STABLE_CYC   = 1024,
  parameter int MIN_ASSERT_CYC    = 16,
  parameter int PERIPH_TO_CPU_CYC = 8
) (
  input logic      clk_i,
  input logic      rst_i,
  rst_seq_if.slave bus
);

  localparam int MAXC = max3(LOCK_STABLE_CYC, MIN_ASSERT_CYC,
                             PERIPH_TO_CPU_CYC);
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] MA_T = CW'(MIN_ASSERT_CYC - 1);
  localparam logic [CW-1:0] LS_T = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] PC_T = CW'(PERIPH_TO_CPU_CYC - 1);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYC < 1 || LOCK_STABLE_CYC < 1 ||
      MIN_ASSERT_CYC < 1 || PERIPH_TO_CPU_CYC < 1) begin : g_param_chk
    $error("rst_seq: stage count >= 2 and cycle counts >= 1 required");
  end

  logic lock_s;
  logic btn_s;
  logic lock_lost;
  logic btn_press;

  rst_seq_sync_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(1),
    .RST_VAL     (1'b0)
  ) u_lock_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .async_i(bus.pll_locked_i),
    .level_o(lock_s)
  );

  rst_seq_sync_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .RST_VAL     (1'b1)
  ) u_btn_db (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .async_i(bus.btn_rst_n_i),
    .level_o(btn_s)
  );

  assign lock_lost = !lock_s;
  assign btn_press = !btn_s;

  state_e        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    cause, cause_n;
  logic          periph_q, cpu_q, run_q;

  logic       exit_req;
  logic [1:0] exit_cause;

  // Exit sources in priority order; sw request only counts in RUN.
  always_comb begin
    exit_req   = 1'b0;
    exit_cause = cause;
    priority case (1'b1)
      lock_lost: begin
        exit_req   = 1'b1;
        exit_cause = CAUSE_PLL;
      end
      btn_press: begin
        exit_req   = 1'b1;
        exit_cause = CAUSE_BTN;
      end
      (bus.sw_rst_req_i && state == RUN): begin
        exit_req   = 1'b1;
        exit_cause = CAUSE_SW;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cause_n = cause;
    unique case (state)
      ASSERT: begin
        if (cnt != MA_T) begin
          cnt_n = cnt + CW'(1);
        end else if (!btn_press) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end
      end
      WAIT_LOCK: begin
        cnt_n = '0;
        if (btn_press) begin
          state_n = ASSERT;
          cause_n = CAUSE_BTN;
        end else if (lock_s) begin
          state_n = STAB;
        end
      end
      STAB: begin
        if (lock_lost) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == LS_T) begin
          state_n = REL_PERIPH;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      REL_PERIPH: begin
        if (exit_req) begin
          state_n = ASSERT;
          cnt_n   = '0;
          cause_n = exit_cause;
        end else if (cnt == PC_T) begin
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RUN: begin
        cnt_n = '0;
        if (exit_req) begin
          state_n = ASSERT;
          cause_n = exit_cause;
        end
      end
      default: begin
        state_n = ASSERT;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs come from the next state so they change on the decision edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ASSERT;
      cnt      <= '0;
      cause    <= CAUSE_POR;
      periph_q <= 1'b1;
      cpu_q    <= 1'b1;
      run_q    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cause    <= cause_n;
      periph_q <= state_n inside {ASSERT, WAIT_LOCK, STAB};
      cpu_q    <= (state_n != RUN);
      run_q    <= (state_n == RUN);
    end
  end

  assign bus.periph_rst_o = periph_q;
  assign bus.cpu_rst_o    = cpu_q;
  assign bus.rst_cause_o  = cause;
  assign bus.run_o        = run_q;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_rst_seq;
  import rst_seq_pkg::*;

  localparam int SS = 2;
  localparam int DB = 4;
  localparam int LS = 8;
  localparam int MA = 4;
  localparam int PC = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  rst_seq_if bus ();

  rst_seq #(
    .SYNC_STAGES      (SS),
    .DEBOUNCE_CYC     (DB),
    .LOCK_STABLE_CYC  (LS),
    .MIN_ASSERT_CYC   (MA),
    .PERIPH_TO_CPU_CYC(PC)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Model phases: 0 assert, 1 wait lock, 2 stab, 3 rel periph, 4 run
  bit         lq[$];
  bit         bq[$];
  bit         m_db;
  int         m_run;
  int         m_ph;
  int         m_t;
  logic [1:0] m_cause;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  task automatic m_reset();
    lq.delete();
    bq.delete();
    for (int i = 0; i < SS; i++) begin
      lq.push_back(1'b0);
      bq.push_back(1'b0);
    end
    m_db    = 1'b1;
    m_run   = 0;
    m_ph    = 0;
    m_t     = 0;
    m_cause = CAUSE_POR;
  endtask

  task automatic m_go(input int p);
    m_ph = p;
    m_t  = 0;
  endtask

  task automatic m_exit(input logic [1:0] c);
    m_cause = c;
    m_go(0);
  endtask

  task automatic step(input bit r, input bit l, input bit b, input bit s);
    bit ls;
    bit bp;
    rst              = r;
    bus.pll_locked_i = l;
    bus.btn_rst_n_i  = b;
    bus.sw_rst_req_i = s;
    ls = lq[0];
    bp = !m_db;
    if (r) begin
      m_reset();
    end else begin
      if (bq[0] != m_db) begin
        if (m_run >= DB - 1) begin
          m_db  = bq[0];
          m_run = 0;
        end else begin
          m_run++;
        end
      end else begin
        m_run = 0;
      end
      lq.push_back(l);
      void'(lq.pop_front());
      bq.push_back(b);
      void'(bq.pop_front());
      case (m_ph)
        0: if (m_t < MA - 1) m_t++; else if (!bp) m_go(1);
        1: if (bp) m_exit(CAUSE_BTN); else if (ls) m_go(2);
        2: if (!ls) m_go(1); else if (m_t < LS - 1) m_t++; else m_go(3);
        3: begin
          if (!ls) m_exit(CAUSE_PLL);
          else if (bp) m_exit(CAUSE_BTN);
          else if (m_t < PC - 1) m_t++;
          else m_go(4);
        end
        default: begin
          if (!ls) m_exit(CAUSE_PLL);
          else if (bp) m_exit(CAUSE_BTN);
          else if (s) m_exit(CAUSE_SW);
        end
      endcase
    end
    @(posedge clk);
    #1;
    check("periph", 32'(bus.periph_rst_o), 32'(m_ph < 3));
    check("cpu", 32'(bus.cpu_rst_o), 32'(m_ph != 4));
    check("run", 32'(bus.run_o), 32'(m_ph == 4));
    check("cause", 32'(bus.rst_cause_o), 32'(m_cause));
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (!bus.run_o && n < 200) begin
      idle();
      n++;
    end
    check("run_reached", 32'(bus.run_o), 32'd1);
  endtask

  initial begin
    int n;
    int lk;
    int bt;
    bit l;
    bit b;
    bit s;
    bit r;

    m_reset();
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0);
    check("rst_periph", 32'(bus.periph_rst_o), 32'd1);
    check("rst_cpu", 32'(bus.cpu_rst_o), 32'd1);
    check("rst_run", 32'(bus.run_o), 32'd0);
    check("rst_cause", 32'(bus.rst_cause_o), 32'(CAUSE_POR));

    // ASSERT 4 + WAIT_LOCK 1 + STAB 8 edges after reset release
    n = 0;
    while (bus.periph_rst_o && n < 100) begin
      idle();
      n++;
    end
    check("por_lat", n, 32'd13);
    n = 0;
    while (bus.cpu_rst_o && n < 100) begin
      idle();
      n++;
    end
    check("rel_gap", n, 32'(PC));
    check("por_run", 32'(bus.run_o), 32'd1);
    check("por_cause", 32'(bus.rst_cause_o), 32'(CAUSE_POR));

    // Lock glitch inside STAB restarts the stability count
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0);
    n = 0;
    repeat (6) begin
      idle();
      n++;
    end
    repeat (2) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      n++;
    end
    while (bus.periph_rst_o && n < 100) begin
      idle();
      n++;
    end
    check("glitch_lat", n, 32'd19);
    check("glitch_cause", 32'(bus.rst_cause_o), 32'(CAUSE_POR));
    wait_run();

    // Bouncing button is filtered, a held press resets the SoC
    repeat (5) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
    end
    check("bounce_run", 32'(bus.run_o), 32'd1);
    n = 0;
    while (!bus.periph_rst_o && n < 50) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    check("btn_lat", n, 32'd7);
    check("btn_cpu", 32'(bus.cpu_rst_o), 32'd1);
    check("btn_cause", 32'(bus.rst_cause_o), 32'(CAUSE_BTN));
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("btn_hold", 32'(bus.periph_rst_o), 32'd1);
    wait_run();
    check("btn_cause2", 32'(bus.rst_cause_o), 32'(CAUSE_BTN));

    // Software request in RUN; a second one during STAB is ignored
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("sw_periph", 32'(bus.periph_rst_o), 32'd1);
    check("sw_cpu", 32'(bus.cpu_rst_o), 32'd1);
    check("sw_cause", 32'(bus.rst_cause_o), 32'(CAUSE_SW));
    n = 0;
    repeat (7) begin
      idle();
      n++;
    end
    step(1'b0, 1'b1, 1'b1, 1'b1);
    n++;
    while (bus.periph_rst_o && n < 100) begin
      idle();
      n++;
    end
    check("sw_lat", n, 32'd13);
    wait_run();
    check("sw_cause2", 32'(bus.rst_cause_o), 32'(CAUSE_SW));

    // Lock loss and debounced press land on the same cycle
    repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0);
    n = 4;
    while (!bus.periph_rst_o && n < 50) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check("prio_lat", n, 32'd7);
    check("prio_cause", 32'(bus.rst_cause_o), 32'(CAUSE_PLL));
    wait_run();

    // Global reset while peripherals are released but CPU is not
    step(1'b0, 1'b1, 1'b1, 1'b1);
    n = 0;
    while (bus.periph_rst_o && n < 100) begin
      idle();
      n++;
    end
    check("mid_cpu", 32'(bus.cpu_rst_o), 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("mid_periph", 32'(bus.periph_rst_o), 32'd1);
    check("mid_cause", 32'(bus.rst_cause_o), 32'(CAUSE_POR));
    wait_run();

    // Random traffic
    lk = 0;
    bt = 0;
    repeat (3000) begin
      if (lk == 0 && $urandom_range(0, 199) == 0)
        lk = int'($urandom_range(1, 3));
      if (bt == 0 && $urandom_range(0, 299) == 0)
        bt = int'($urandom_range(1, 12));
      l = (lk == 0);
      if (lk > 0) lk--;
      b = (bt == 0) || ($urandom_range(0, 7) == 0);
      if (bt > 0) bt--;
      s = ($urandom_range(0, 49) == 0);
      r = ($urandom_range(0, 999) == 0);
      step(r, l, b, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Reset sequencer between the board PLL/reset button and the sigma SoC.
- Synchronizes and debounces the reset button and synchronizes PLL lock.
- Releases peripheral reset first, then CPU reset, in a fixed order with programmable delays.
- Re-enters reset on PLL lock loss, a button press, or a software request, and records the reset cause for firmware.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each asynchronous input.
- DEBOUNCE_CYC, 80000, consecutive stable cycles needed to accept a button level change (1 ms at 80 MHz).
- LOCK_STABLE_CYC, 1024, cycles of continuous lock required before any reset release.
- MIN_ASSERT_CYC, 16, minimum cycles spent in ASSERT.
- PERIPH_TO_CPU_CYC, 8, cycles between peripheral release and CPU release.

Ports:
- clk_i  in  1  system clock (PLL output).
- rst_i  in  1  synchronous, active-high global reset.
- pll_locked_i  in  1  PLL lock, asynchronous.
- btn_rst_n_i  in  1  reset button, active-low, asynchronous, bouncing.
- sw_rst_req_i  in  1  single-cycle software reset request, synchronous to clk_i.
- periph_rst_o  out  1  peripheral reset, active-high, registered.
- cpu_rst_o  out  1  CPU reset, active-high, registered.
- rst_cause_o  out  2  last reset cause: 00 POR, 01 button, 10 PLL loss, 11 software.
- run_o  out  1  high in RUN.

Behaviour:
- Reset values on rst_i: state ASSERT, counter 0, periph_rst_o=1, cpu_rst_o=1, rst_cause_o=00, run_o=0, debounced button = released, sync chains = 0.
- Input conditioning:
  - pll_locked_i and btn_rst_n_i each pass through SYNC_STAGES flip-flops.
  - Debounced button state changes only after the synced level differs from it for DEBOUNCE_CYC consecutive cycles.
  - Any cycle matching the current debounced state clears the debounce counter.
- Events, all evaluated on synced/debounced signals:
  - lock_lost = !lock_s.
  - btn_press = debounced state pressed.
- ASSERT:
  - Drives periph_rst_o=1, cpu_rst_o=1.
  - Counter runs to MIN_ASSERT_CYC-1.
  - Goes to WAIT_LOCK when the count completes and the button is not pressed.
  - While the button is held, stays in ASSERT with the counter held at terminal.
- WAIT_LOCK:
  - Counter cleared.
  - Goes to STAB when lock_s=1.
  - btn_press goes to ASSERT with cause=01.
- STAB:
  - Counts to LOCK_STABLE_CYC-1.
  - lock_s=0 returns to WAIT_LOCK with the counter cleared; cause unchanged.
  - Count complete goes to REL_PERIPH.
- REL_PERIPH:
  - periph_rst_o=0, cpu_rst_o=1.
  - Counts to PERIPH_TO_CPU_CYC-1, then goes to RUN.
- RUN: periph_rst_o=0, cpu_rst_o=0, run_o=1.
- Exit to ASSERT from REL_PERIPH or RUN, with cause written on the same edge:
  - lock_lost gives cause 10.
  - btn_press gives cause 01.
  - sw_rst_req_i, honoured only in RUN and ignored in every other state, gives cause 11.
- Simultaneous events: priority is lock_lost > btn_press > sw request; one cause is recorded.
- Outputs are registered from the next state, so the event cycle N shows periph_rst_o=cpu_rst_o=1 at N+1.
- Release order: periph_rst_o falls exactly PERIPH_TO_CPU_CYC cycles before cpu_rst_o. cpu_rst_o never falls while periph_rst_o=1.
- rst_cause_o holds its value until the next exit event or rst_i; it is readable in RUN.
- Counter width is $clog2 of the maximum cycle parameter plus 1, saturating with no wrap.
- Counter compares use parameter-1; every cycle parameter must be ≥1, checked by an elaboration assertion.

Decomposition:
- Package rst_seq_pkg:
  - State enum {ASSERT, WAIT_LOCK, STAB, REL_PERIPH, RUN}.
  - Cause localparams CAUSE_POR/BTN/PLL/SW (2 bits).
- Sub-module sync_debounce (SYNC_STAGES, DEBOUNCE_CYC, RST_VAL): synchronizer plus debounce counter.
  - Instantiated for the button with DEBOUNCE_CYC as given.
  - Instantiated for lock with DEBOUNCE_CYC=1, i.e. sync only.

Test Plan:
Bench parameters: DEBOUNCE_CYC=4, LOCK_STABLE_CYC=8, MIN_ASSERT_CYC=4, PERIPH_TO_CPU_CYC=3, SYNC_STAGES=2.
- Power-up, rst_i for 3 cycles, lock=1 steady -> periph_rst_o falls ≈4+2+8 cycles after rst_i deasserts; cpu_rst_o falls exactly 3 cycles later; run_o=1; cause=00.
- Lock glitch to 0 for 2 cycles during STAB -> returns to WAIT_LOCK, STAB count restarts, no release until 8 clean lock cycles; cause stays 00.
- In RUN, button low bounces 1-cycle pulses ×5, then held low for 10 cycles -> bounces ignored; held press drives both resets high 2+4+1 cycles after the hold starts; cause=01; stays in ASSERT until release is debounced.
- In RUN, pulse sw_rst_req_i for one cycle -> both resets high next cycle; cause=11; full resequence back to RUN. The same pulse during STAB is ignored.
- In RUN, drop lock and press the button in the same cycle with debounce preset to complete together -> cause=10.
- rst_i asserted mid-REL_PERIPH -> both resets 1, cause=00, state ASSERT on the next edge.
